// File: rtl/fifo_arbiter_nch.sv
// N-channel pixel input FIFOs with a round-robin or fixed-priority arbiter
// feeding the z-buffer; grants come from registered request state only.
module fifo_arbiter_nch #(
  parameter int N_CH        = 4,
  parameter int PIXEL_WIDTH = 16,
  parameter int MEM_LENGTH  = 8,
  parameter int AF_THRESH   = 6,
  parameter int ARB_MODE    = 0,
  localparam int FW = $clog2(MEM_LENGTH) + 1,
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CH*PIXEL_WIDTH-1:0] pix_in,
  input  logic [N_CH-1:0]             load,
  input  logic                        rdy_z_buffer,
  output logic [PIXEL_WIDTH-1:0]      pix_out,
  output logic [IW-1:0]               src_id,
  output logic                        send_z_buffer,
  output logic [N_CH*FW-1:0]          fill,
  output logic [N_CH-1:0]             req,
  output logic [N_CH-1:0]             almost_full,
  output logic [N_CH-1:0]             full,
  output logic [N_CH-1:0]             overflow
);

  localparam int AW = $clog2(MEM_LENGTH);

  logic [PIXEL_WIDTH-1:0] mem_q [N_CH][MEM_LENGTH];
  logic [PIXEL_WIDTH-1:0] mem_d [N_CH][MEM_LENGTH];
  logic [AW-1:0]          wr_ptr_q [N_CH];
  logic [AW-1:0]          wr_ptr_d [N_CH];
  logic [AW-1:0]          rd_ptr_q [N_CH];
  logic [AW-1:0]          rd_ptr_d [N_CH];
  logic [FW-1:0]          fill_q [N_CH];
  logic [FW-1:0]          fill_d [N_CH];
  logic [N_CH-1:0]        req_q, req_d;
  logic [N_CH-1:0]        af_q, af_d;
  logic [N_CH-1:0]        full_q, full_d;
  logic [N_CH-1:0]        ovf_q, ovf_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [PIXEL_WIDTH-1:0] pix_out_q, pix_out_d;
  logic [IW-1:0]          src_id_q, src_id_d;
  logic                   send_q, send_d;

  logic                   grant_valid_s;
  logic [IW-1:0]          grant_idx_s;
  logic [IW-1:0]          cand_s;
  logic [N_CH-1:0]        pop_s;
  logic [N_CH-1:0]        accept_s;
  logic [PIXEL_WIDTH-1:0] pop_word_s;

  // Arbitration over the registered request vector.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    if (rdy_z_buffer) begin
      if (ARB_MODE == 0) begin
        for (int k = 1; k <= N_CH; k++) begin
          cand_s = IW'((int'(rr_ptr_q) + k) % N_CH);
          if (!grant_valid_s && req_q[cand_s]) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = cand_s;
          end else begin
            grant_valid_s = grant_valid_s;
          end
        end
      end else begin
        for (int k = 0; k < N_CH; k++) begin
          cand_s = IW'(k);
          if (!grant_valid_s && req_q[cand_s]) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = cand_s;
          end else begin
            grant_valid_s = grant_valid_s;
          end
        end
      end
    end else begin
      grant_valid_s = 1'b0;
    end
  end

  // Per-channel FIFO next state; a pop on a full channel frees the slot for a same-edge load.
  always_comb begin
    mem_d      = mem_q;
    pop_s      = '0;
    accept_s   = '0;
    ovf_d      = ovf_q;
    req_d      = '0;
    af_d       = '0;
    full_d     = '0;
    pop_word_s = mem_q[grant_idx_s][rd_ptr_q[grant_idx_s]];
    for (int i = 0; i < N_CH; i++) begin
      pop_s[i]    = grant_valid_s && (grant_idx_s == IW'(i));
      accept_s[i] = load[i] && (!full_q[i] || pop_s[i]);
      if (load[i] && full_q[i] && !pop_s[i]) begin
        ovf_d[i] = 1'b1;
      end else begin
        ovf_d[i] = ovf_q[i];
      end
      if (accept_s[i]) begin
        mem_d[i][wr_ptr_q[i]] = pix_in[i*PIXEL_WIDTH +: PIXEL_WIDTH];
        wr_ptr_d[i]           = wr_ptr_q[i] + AW'(1);
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i];
      end
      if (pop_s[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
      end else begin
        rd_ptr_d[i] = rd_ptr_q[i];
      end
      if (accept_s[i] && !pop_s[i]) begin
        fill_d[i] = fill_q[i] + FW'(1);
      end else if (!accept_s[i] && pop_s[i]) begin
        fill_d[i] = fill_q[i] - FW'(1);
      end else begin
        fill_d[i] = fill_q[i];
      end
      req_d[i]  = (fill_d[i] != FW'(0));
      af_d[i]   = (fill_d[i] >= FW'(AF_THRESH));
      full_d[i] = (fill_d[i] == FW'(MEM_LENGTH));
    end
  end

  // Output register and round-robin pointer next state.
  always_comb begin
    if (grant_valid_s) begin
      pix_out_d = pop_word_s;
      src_id_d  = grant_idx_s;
      send_d    = 1'b1;
      rr_ptr_d  = (ARB_MODE == 0) ? grant_idx_s : rr_ptr_q;
    end else begin
      pix_out_d = pix_out_q;
      src_id_d  = src_id_q;
      send_d    = 1'b0;
      rr_ptr_d  = rr_ptr_q;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        fill_q[i]   <= '0;
      end
      req_q     <= '0;
      af_q      <= '0;
      full_q    <= '0;
      ovf_q     <= '0;
      rr_ptr_q  <= IW'(N_CH - 1);
      pix_out_q <= '0;
      src_id_q  <= '0;
      send_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      req_q     <= req_d;
      af_q      <= af_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      rr_ptr_q  <= rr_ptr_d;
      pix_out_q <= pix_out_d;
      src_id_q  <= src_id_d;
      send_q    <= send_d;
    end
  end

  // Storage array; contents are don't-care while the pointers are reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Flatten per-channel fill counts onto the output bus.
  always_comb begin
    fill = '0;
    for (int i = 0; i < N_CH; i++) begin
      fill[i*FW +: FW] = fill_q[i];
    end
  end

  assign pix_out       = pix_out_q;
  assign src_id        = src_id_q;
  assign send_z_buffer = send_q;
  assign req           = req_q;
  assign almost_full   = af_q;
  assign full          = full_q;
  assign overflow      = ovf_q;

endmodule

// File: doc/fifo_arbiter_nch.md
Name: fifo_arbiter_nch

Overview:
Parametrised N-channel input buffer and arbiter feeding the z-buffer. It generalises the 4-channel fifo/contention-tree pair to arbitrary channel count, depth and pixel width. It adds selectable round-robin or fixed-priority arbitration, source-ID tagging, almost-full back-pressure and sticky overflow flags. It sits between the N rasteriser pixel streams and the z-buffer input port.

Parameters:
N_CH, 4, number of input channels (2..16)
PIXEL_WIDTH, 16, pixel word width in bits
MEM_LENGTH, 8, FIFO depth per channel (power of 2, >=2)
AF_THRESH, 6, almost_full asserts when fill >= AF_THRESH (1..MEM_LENGTH)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)
Derived: FW = $clog2(MEM_LENGTH)+1, IW = max(1,$clog2(N_CH))

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (reset==0 clears state at the rising edge)
pix_in  in  N_CH*PIXEL_WIDTH  channel i pixel at bits [i*PIXEL_WIDTH +: PIXEL_WIDTH]
load  in  N_CH  per-channel write strobe
rdy_z_buffer  in  1  z-buffer can accept a pixel this cycle
pix_out  out  PIXEL_WIDTH  granted pixel, registered
src_id  out  IW  channel index of pix_out
send_z_buffer  out  1  pix_out/src_id valid this cycle (single-cycle pulse per pixel)
fill  out  N_CH*FW  per-channel occupancy 0..MEM_LENGTH
req  out  N_CH  req[i] = fill_i != 0
almost_full  out  N_CH  fill_i >= AF_THRESH
full  out  N_CH  fill_i == MEM_LENGTH
overflow  out  N_CH  sticky: a load was dropped on channel i

Behaviour:
- Reset (reset==0 at rising edge): all FIFOs emptied, pointers 0, fill/req/almost_full/full/overflow = 0, pix_out = 0, src_id = 0, send_z_buffer = 0, RR pointer = N_CH-1 so channel 0 wins first. Reset dominates load/rdy in the same cycle. Reset mid-stream discards all buffered pixels, with no output pulse in that cycle.
- Write: load[i]=1 at edge k stores pix_in_i; fill_i increments after edge k. If full[i]=1 and there is no pop on i that same edge, the word is dropped, fill unchanged and overflow[i] set. overflow clears only on reset.
- Arbitration at each edge: eligible set = req (registered, pre-edge state). If rdy_z_buffer=1 and eligible nonempty, grant channel g and pop its head.
  - ARB_MODE=0: g = first eligible index after the last grant, cyclic. Pointer updates to g only on a grant.
  - ARB_MODE=1: g = lowest eligible index. No pointer.
- Output: on a grant at edge k, after edge k: pix_out = popped word, src_id = g, send_z_buffer = 1. With no grant: send_z_buffer = 0, and pix_out/src_id hold their last value.
- Latency: load at edge k -> earliest pop at edge k+1 -> send_z_buffer high in cycle after k+1. A word written to an empty FIFO is never popped in the same edge.
- Simultaneous load and pop on the same channel: both occur, fill unchanged. This is accepted even when full (the pop frees the slot), with no overflow.
- rdy_z_buffer=0: no pop, FIFOs only fill. Throughput is 1 pixel/cycle total while rdy=1.
- FIFO pointers wrap modulo MEM_LENGTH. fill uses FW bits to distinguish full from empty.
- Per-channel order is strictly preserved.

Test Plan:
- Defaults, RR. Load 0x0001..0x0004 on ch0..3 simultaneously, rdy=1 -> four consecutive send pulses: (0x0001,id0), (0x0002,id1), (0x0003,id2), (0x0004,id3). Then fill all 0, req=0000.
- Overflow. rdy=0, 9 loads on ch0 with 0x10..0x18 -> fill_0 = 8, full[0]=1, almost_full[0]=1 from the 6th load, overflow[0]=1. Then rdy=1 -> outputs 0x10..0x17 only, overflow stays 1.
- RR fairness. ch0 holds A0,A1,A2 and ch2 holds C0,C1,C2, rdy=1 -> order A0,C0,A1,C1,A2,C2 with ids 0,2,0,2,0,2.
- ARB_MODE=1, same preload -> A0,A1,A2,C0,C1,C2.
- Back-pressure. Drop rdy for 3 cycles mid-stream -> send_z_buffer=0 for exactly those cycles, pix_out holds its value, and the stream resumes with no loss or duplication.
- Full+load+pop on ch1 (fill=8, rdy=1, only ch1 requesting) -> fill stays 8, overflow[1]=0. Then assert reset=0 for one edge -> all outputs 0, and subsequent rdy=1 yields no send.
